// File: rtl/prach_result_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prach_pkg
// Description : Shared widths, result record and FSM state type for the PRACH
//               result transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package prach_pkg;

  localparam int RES_BW = 24;
  localparam int IDX_BW = 8;
  localparam int TA_BW  = 16;

  // One detection result as stored in the buffer: index in the upper byte,
  // timing advance in the lower half-word.
  typedef struct packed {
    logic [IDX_BW-1:0] idx;
    logic [TA_BW-1:0]  ta;
  } prach_res_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/prach_result_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : prach_result_tx_if
// Description : AXI-stream result bus of the PRACH result transmitter.
//               master : drives data/valid/last/user, receives ready
//               slave  : receives data/valid/last/user, drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface prach_result_tx_if
  import prach_pkg::*;
#(
  parameter int bw_user = 4
) ();

  logic [IDX_BW-1:0]  axiTx_Data_RA_PreambleIdxs;
  logic [TA_BW-1:0]   axiTx_Data_TA;
  logic               axiTx_Valid;
  logic               axiTx_Last;
  logic [bw_user-1:0] axiTx_User;
  logic               axiTx_Ready;

  modport master (
    output axiTx_Data_RA_PreambleIdxs,
    output axiTx_Data_TA,
    output axiTx_Valid,
    output axiTx_Last,
    output axiTx_User,
    input  axiTx_Ready
  );

  modport slave (
    input  axiTx_Data_RA_PreambleIdxs,
    input  axiTx_Data_TA,
    input  axiTx_Valid,
    input  axiTx_Last,
    input  axiTx_User,
    output axiTx_Ready
  );

endinterface
`default_nettype wire

// File: rtl/prach_result_tx_ram.sv
`default_nettype none
// ============================================================================
// Module      : prach_res_ram
// Description : Simple dual-port result buffer, DEPTH x RES_BW, synchronous
//               read with registered read data. Contents are not reset.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable (read register holds when low)
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module prach_res_ram
  import prach_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire prach_res_t    wdata_i,
  input  wire logic          re_i,
  input  wire logic [AW-1:0] raddr_i,
  output prach_res_t         rdata_o
);

  prach_res_t mem_q [DEPTH];
  prach_res_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Read-during-write to the same address returns the new word; this is
    // what lets a single result written on the search_done cycle go out as
    // the very next beat.
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/prach_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : prach_result_tx
// Description : Collects PRACH detection results during a search pass and
//               streams them out as one AXI-stream packet once the pass ends.
//   clk                  in   rising-edge clock
//   rst                  in   asynchronous active-high reset
//   res_valid_i          in   one detected preamble this cycle
//   res_idx_i            in   RA preamble index
//   res_ta_i             in   timing advance
//   search_done_i        in   single-cycle pulse, detection pass finished
//   axis                 master AXI-stream result bus (data/valid/last/user/ready)
//   count_preambles_o    out  number of results in the most recent pass
//   no_prach_detected_o  out  one-cycle pulse, pass ended with no results
//   busy_o               out  high while a packet is being sent
// Revision    : 1.0 - initial release
// ============================================================================
module prach_result_tx
  import prach_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int bw_user = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              res_valid_i,
  input  wire logic [IDX_BW-1:0] res_idx_i,
  input  wire logic [TA_BW-1:0]  res_ta_i,
  input  wire logic              search_done_i,
  prach_result_tx_if.master      axis,
  output logic [6:0]             count_preambles_o,
  output logic                   no_prach_detected_o,
  output logic                   busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 7;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            nop_q, nop_d;

  logic            w_ram_we;
  logic            w_ram_re;
  logic [AW-1:0]   w_ram_raddr;
  prach_res_t      w_ram_wdata;
  prach_res_t      w_ram_rdata;

  logic            w_full;
  logic            w_accept;
  logic [PW-1:0]   w_final_cnt;
  logic            w_valid;
  logic            w_last;
  logic            w_xfer;
  logic [bw_user-1:0] w_user;

  assign w_full      = (wr_ptr_q == DEPTH_P);
  assign w_accept    = res_valid_i && !w_full;
  // Entry count as it will stand after this cycle, so a result arriving with
  // search_done is counted in the pass it closes.
  assign w_final_cnt = wr_ptr_q + {{(PW-1){1'b0}}, w_accept};
  assign w_valid     = (state_q == SEND);
  assign w_last      = (rd_ptr_q == (count_q - 7'd1));
  assign w_xfer      = w_valid && axis.axiTx_Ready;
  assign w_ram_wdata = '{idx: res_idx_i, ta: res_ta_i};

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    nop_d       = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_raddr = rd_ptr_q[AW-1:0] + AW'(1);

    case (state_q)
      COLLECT: begin
        if (res_valid_i) begin
          if (w_full) begin
            ovf_d = 1'b1;
          end else begin
            w_ram_we = 1'b1;
            wr_ptr_d = wr_ptr_q + 7'd1;
          end
        end
        if (search_done_i) begin
          count_d = w_final_cnt;
          if (w_final_cnt == '0) begin
            nop_d = 1'b1;
          end else begin
            // Prefetch entry 0 now so the first beat is valid next cycle.
            state_d     = SEND;
            w_ram_re    = 1'b1;
            w_ram_raddr = '0;
          end
        end
      end

      SEND: begin
        if (w_xfer) begin
          if (w_last) begin
            state_d  = COLLECT;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
          end else begin
            // Read-ahead: fetch the following entry on the accepting edge so
            // it is presented back-to-back with no bubble.
            rd_ptr_d = rd_ptr_q + 7'd1;
            w_ram_re = 1'b1;
          end
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      nop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      nop_q    <= nop_d;
    end
  end

  prach_res_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (w_ram_wdata),
    .re_i    (w_ram_re),
    .raddr_i (w_ram_raddr),
    .rdata_o (w_ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Outputs. The RAM read register is not reset, so beat fields are gated by
  // Valid; this makes them zero the instant reset is applied.
  // --------------------------------------------------------------------------
  always_comb begin
    w_user    = '0;
    w_user[0] = w_valid && ovf_q;
  end

  assign axis.axiTx_Valid                = w_valid;
  assign axis.axiTx_Last                 = w_valid && w_last;
  assign axis.axiTx_User                 = w_user;
  assign axis.axiTx_Data_RA_PreambleIdxs = w_valid ? w_ram_rdata.idx : '0;
  assign axis.axiTx_Data_TA              = w_valid ? w_ram_rdata.ta  : '0;

  assign count_preambles_o   = count_q;
  assign no_prach_detected_o = nop_q;
  assign busy_o              = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_prach_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_prach_result_tx
// Description : Self-checking bench for prach_result_tx. A queue-based model
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations on the transferred beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prach_result_tx;

  localparam int DEPTH   = 64;
  localparam int BW_USER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       res_valid = 1'b0;
  logic [7:0] res_idx = '0;
  logic [15:0] res_ta = '0;
  logic       search_done = 1'b0;
  logic [6:0] count_preambles;
  logic       no_prach_detected;
  logic       busy;

  prach_result_tx_if #(.bw_user(BW_USER)) axis ();

  prach_result_tx #(.DEPTH(DEPTH), .bw_user(BW_USER)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .res_valid_i         (res_valid),
    .res_idx_i           (res_idx),
    .res_ta_i            (res_ta),
    .search_done_i       (search_done),
    .axis                (axis.master),
    .count_preambles_o   (count_preambles),
    .no_prach_detected_o (no_prach_detected),
    .busy_o              (busy)
  );

  always #5 clk = ~clk;

  logic ready = 1'b0;
  assign axis.axiTx_Ready = ready;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: results accumulate in m_buf during a pass; search_done hands the
  // whole list over as m_pkt, which drains one element per accepted beat.
  // --------------------------------------------------------------------------
  logic [23:0] m_buf[$];
  logic [23:0] m_pkt[$];
  bit          m_sending = 0;
  bit          m_ovf     = 0;
  int          m_count   = 0;
  bit          m_nop     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_buf.delete(); m_pkt.delete();
      m_sending = 0; m_ovf = 0; m_count = 0; m_nop = 0;
    end else begin
      m_nop = 0;
      if (!m_sending) begin
        if (res_valid) begin
          if (m_buf.size() < DEPTH) m_buf.push_back({res_idx, res_ta});
          else m_ovf = 1;
        end
        if (search_done) begin
          m_count = m_buf.size();
          if (m_count == 0) m_nop = 1;
          else begin
            m_pkt = m_buf;
            m_buf.delete();
            m_sending = 1;
          end
        end
      end else if (ready) begin
        void'(m_pkt.pop_front());
        if (m_pkt.size() == 0) begin
          m_sending = 0;
          m_ovf = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid", 32'(axis.axiTx_Valid), 32'(m_sending));
    chk("busy", 32'(busy), 32'(m_sending));
    chk("nop", 32'(no_prach_detected), 32'(m_nop));
    chk("count", 32'(count_preambles), 32'(m_count));
    if (m_sending && !rst) begin
      chk("idx", 32'(axis.axiTx_Data_RA_PreambleIdxs), 32'(m_pkt[0][23:16]));
      chk("ta", 32'(axis.axiTx_Data_TA), 32'(m_pkt[0][15:0]));
      chk("last", 32'(axis.axiTx_Last), 32'(m_pkt.size() == 1));
      chk("user", 32'(axis.axiTx_User), {31'd0, m_ovf});
    end else if (rst) begin
      chk("rst_last", 32'(axis.axiTx_Last), 32'd0);
      chk("rst_user", 32'(axis.axiTx_User), 32'd0);
      chk("rst_data", {8'd0, axis.axiTx_Data_RA_PreambleIdxs, axis.axiTx_Data_TA}, 32'd0);
    end
  end

  // Log of transferred beats: {last, user0, idx, ta}
  logic [25:0] beats[$];
  always @(posedge clk) begin
    if (!rst && axis.axiTx_Valid && axis.axiTx_Ready)
      beats.push_back({axis.axiTx_Last, axis.axiTx_User[0],
                       axis.axiTx_Data_RA_PreambleIdxs, axis.axiTx_Data_TA});
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] idx, input logic [15:0] ta);
    res_valid = 1'b1; res_idx = idx; res_ta = ta;
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic done();
    search_done = 1'b1;
    cyc();
    search_done = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300 && busy; i++) cyc();
    n_checks++;
    if (busy) begin
      n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", i);
    end
    cyc();
  endtask

  task automatic chk_beat(input int k, input logic [7:0] idx, input logic [15:0] ta,
                          input logic last, input logic usr);
    logic [25:0] exp;
    exp = {last, usr, idx, ta};
    if (k < beats.size()) chk($sformatf("beat%0d", k), 32'(beats[k]), 32'(exp));
    else chk($sformatf("beat%0d_missing", k), 32'(beats.size()), 32'(k + 1));
  endtask

  logic ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int bad_user;
    // Reset
    #2 rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_valid", 32'(axis.axiTx_Valid), 32'd0);
    chk("reset_count", 32'(count_preambles), 32'd0);

    // Three results, ready held high
    ready = 1'b1;
    beats.delete();
    push(8'd5, 16'd100);
    push(8'd12, 16'd2000);
    push(8'd63, 16'd65535);
    done();
    chk("first_valid_latency", 32'(axis.axiTx_Valid), 32'd1);
    wait_idle();
    chk("p3_size", 32'(beats.size()), 32'd3);
    chk_beat(0, 8'd5, 16'd100, 1'b0, 1'b0);
    chk_beat(1, 8'd12, 16'd2000, 1'b0, 1'b0);
    chk_beat(2, 8'd63, 16'd65535, 1'b1, 1'b0);
    chk("p3_count", 32'(count_preambles), 32'd3);

    // Empty pass
    done();
    chk("empty_nop", 32'(no_prach_detected), 32'd1);
    chk("empty_valid", 32'(axis.axiTx_Valid), 32'd0);
    chk("empty_count", 32'(count_preambles), 32'd0);
    cyc();
    chk("empty_nop_once", 32'(no_prach_detected), 32'd0);
    chk("empty_valid2", 32'(axis.axiTx_Valid), 32'd0);

    // Four results with backpressure
    beats.delete();
    push(8'd1, 16'h1111); push(8'd2, 16'h2222); push(8'd3, 16'h3333); push(8'd4, 16'h4444);
    done();
    for (int k = 0; k < 7; k++) begin
      ready = ready_pat[k];
      cyc();
    end
    ready = 1'b1;
    wait_idle();
    chk("bp_size", 32'(beats.size()), 32'd4);
    chk_beat(0, 8'd1, 16'h1111, 1'b0, 1'b0);
    chk_beat(1, 8'd2, 16'h2222, 1'b0, 1'b0);
    chk_beat(2, 8'd3, 16'h3333, 1'b0, 1'b0);
    chk_beat(3, 8'd4, 16'h4444, 1'b1, 1'b0);

    // Overflow: 70 results into 64 entries
    beats.delete();
    for (int i = 0; i < 70; i++) push(8'(i), 16'(i * 7));
    done();
    wait_idle();
    chk("ovf_size", 32'(beats.size()), 32'd64);
    chk("ovf_count", 32'(count_preambles), 32'd64);
    bad_user = 0;
    foreach (beats[k]) if (beats[k][24] !== 1'b1) bad_user++;
    chk("ovf_user_all", 32'(bad_user), 32'd0);
    chk_beat(63, 8'd63, 16'd441, 1'b1, 1'b1);
    beats.delete();
    push(8'd77, 16'd7);
    done();
    wait_idle();
    chk("post_ovf_size", 32'(beats.size()), 32'd1);
    chk_beat(0, 8'd77, 16'd7, 1'b1, 1'b0);

    // Same-cycle result with search_done; inputs during SEND ignored
    beats.delete();
    push(8'd10, 16'd1000);
    push(8'd11, 16'd1100);
    res_valid = 1'b1; res_idx = 8'd12; res_ta = 16'd1200;
    done();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_idx = 8'(90 + i); res_ta = 16'(9000 + i);
      search_done = (i == 1);
      cyc();
    end
    res_valid = 1'b0; search_done = 1'b0;
    ready = 1'b1;
    wait_idle();
    chk("same_size", 32'(beats.size()), 32'd3);
    chk_beat(0, 8'd10, 16'd1000, 1'b0, 1'b0);
    chk_beat(1, 8'd11, 16'd1100, 1'b0, 1'b0);
    chk_beat(2, 8'd12, 16'd1200, 1'b1, 1'b0);
    beats.delete();
    push(8'd20, 16'd2020);
    done();
    wait_idle();
    chk("next_size", 32'(beats.size()), 32'd1);
    chk_beat(0, 8'd20, 16'd2020, 1'b1, 1'b0);

    // Reset in the middle of a 5-beat packet
    beats.delete();
    for (int i = 0; i < 5; i++) push(8'(40 + i), 16'(400 + i));
    done();
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(axis.axiTx_Valid), 32'd0);
    chk("midrst_last", 32'(axis.axiTx_Last), 32'd0);
    chk("midrst_count", 32'(count_preambles), 32'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("midrst_beats", 32'(beats.size()), 32'd2);
    chk_beat(0, 8'd40, 16'd400, 1'b0, 1'b0);
    chk_beat(1, 8'd41, 16'd401, 1'b0, 1'b0);
    beats.delete();
    push(8'd50, 16'd500);
    push(8'd51, 16'd501);
    done();
    wait_idle();
    chk("after_rst_size", 32'(beats.size()), 32'd2);
    chk_beat(0, 8'd50, 16'd500, 1'b0, 1'b0);
    chk_beat(1, 8'd51, 16'd501, 1'b1, 1'b0);
    chk("after_rst_count", 32'(count_preambles), 32'd2);

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
